// File: rtl/regfile_pkg.sv
// Shared types and constants for the decode-stage register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    // Clear sequencer states
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Default geometry: 32 registers of 32 bits, two read ports
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    // Number of registers addressed by an addr_w-bit index
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits used by decode for RAW hazard detection.
// Latency: set/clear land at the clock edge; lookups are combinational.
// Backpressure: none; callers gate set/clear (e.g. during clear).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_vld,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr_vld,
    input  logic [ADDR_W-1:0]        clr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] lk_addr,
    output logic [NUM_RD-1:0]        lk_pend
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Next pending vector: a same-cycle reserve beats the write-back clear,
    // because the reserve belongs to a newer producer of the same register
    always_comb begin
        pend_d = pend_q;
        if (clr_vld) begin
            pend_d[clr_addr] = 1'b0;
        end
        if (set_vld) begin
            pend_d[set_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Pending register; reset empties the whole scoreboard
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Independent lookup per read port
    always_comb begin
        lk_pend = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            lk_pend[k] = pend_q[lk_addr[k*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with hardware clear sequencer and pending scoreboard.
// Latency: reads combinational; writes/reserves visible next cycle; clear takes DEPTH-1 cycles.
// Backpressure: none; ready is low during clear and writes/reserves are dropped. Option: REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rpend
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   clr_ptr_q;
    logic [ADDR_W-1:0]   clr_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    logic                wr_en;
    logic                rsv_en;
    logic [NUM_RD-1:0]   lk_pend;

    assign ready  = (state_q == ST_READY);
    // Register 0 is hardwired, so traffic to it never reaches the array or scoreboard
    assign wr_en  = ready && we && (waddr != '0);
    assign rsv_en = ready && rsv_valid && (rsv_addr != '0);

    // Clear sequencer: walk entries 1..DEPTH-1, then open for traffic
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Sequencer state; reset restarts the sweep from entry 1
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= ADDR_W'(1);
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Array update: the clear sweep owns the write port until ready
    always_comb begin
        mem_d = mem_q;
        if (state_q == ST_CLEAR) begin
            mem_d[clr_ptr_q] = '0;
        end else if (wr_en) begin
            mem_d[waddr] = wdata;
        end
    end

    // Array storage; no reset, contents are zeroed by the sweep instead
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_vld  (rsv_en),
        .set_addr (rsv_addr),
        .clr_vld  (wr_en),
        .clr_addr (waddr),
        .lk_addr  (raddr),
        .lk_pend  (lk_pend)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_dat;
        logic              rd_pend;

        assign rd_addr = raddr[k*ADDR_W +: ADDR_W];

        // Read mux: zero while clearing or for register 0, optional write-first bypass
        always_comb begin
            rd_dat  = '0;
            rd_pend = 1'b0;
            if (ready && (rd_addr != '0)) begin
                rd_dat  = mem_q[rd_addr];
                rd_pend = lk_pend[k];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (rd_addr == waddr)) begin
                rd_dat  = wdata;
                rd_pend = 1'b0;
            end
`endif
        end

        assign rdata[k*DATA_W +: DATA_W] = rd_dat;
        assign rpend[k]                  = rd_pend;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default and 64x16x3 configurations).
// Latency: checks reads combinationally and state updates one cycle after the edge.
// Backpressure: n/a.
module tb_regfile_sb;

    logic clk;
    int   total;
    int   bad;

    // Instance A: default 32-bit, 32 entries, 2 read ports
    logic        a_rst, a_ready, a_we, a_rsv_valid;
    logic [4:0]  a_waddr, a_rsv_addr;
    logic [31:0] a_wdata;
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rpend;

    // Instance B: 64-bit, 16 entries, 3 read ports
    logic         b_rst, b_ready, b_we, b_rsv_valid;
    logic [3:0]   b_waddr, b_rsv_addr;
    logic [63:0]  b_wdata;
    logic [11:0]  b_raddr;
    logic [191:0] b_rdata;
    logic [2:0]   b_rpend;

    regfile_sb u_dut_a (
        .clk       (clk),
        .rst       (a_rst),
        .ready     (a_ready),
        .we        (a_we),
        .waddr     (a_waddr),
        .wdata     (a_wdata),
        .rsv_valid (a_rsv_valid),
        .rsv_addr  (a_rsv_addr),
        .raddr     (a_raddr),
        .rdata     (a_rdata),
        .rpend     (a_rpend)
    );

    regfile_sb #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3)) u_dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .ready     (b_ready),
        .we        (b_we),
        .waddr     (b_waddr),
        .wdata     (b_wdata),
        .rsv_valid (b_rsv_valid),
        .rsv_addr  (b_rsv_addr),
        .raddr     (b_raddr),
        .rdata     (b_rdata),
        .rpend     (b_rpend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic a_idle();
        a_we = 1'b0; a_waddr = '0; a_wdata = '0;
        a_rsv_valid = 1'b0; a_rsv_addr = '0;
    endtask

    task automatic b_idle();
        b_we = 1'b0; b_waddr = '0; b_wdata = '0;
        b_rsv_valid = 1'b0; b_rsv_addr = '0;
    endtask

    // Reset pulse, 31-cycle clear, traffic during clear dropped, all zero afterwards
    task automatic test_reset();
        logic [4:0] ad;
        a_idle();
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        a_we = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEADBEEF;
        a_rsv_valid = 1'b1; a_rsv_addr = 5'd6;
        a_raddr = {5'd6, 5'd5};
        for (int n = 0; n <= 31; n++) begin
            #1;
            total++;
            if (a_ready !== (n == 31)) begin
                bad++;
                $display("FAIL reset_ready n=%0d: got %b want %b", n, a_ready, (n == 31));
            end
            if (n < 31) begin
                total++;
                if (a_rdata !== 64'h0 || a_rpend !== 2'b00) begin
                    bad++;
                    $display("FAIL clear_reads n=%0d: rdata %h rpend %b want 0 0", n, a_rdata, a_rpend);
                end
            end
            if (n == 30) a_idle();
            @(negedge clk);
        end
        for (int a = 0; a < 32; a++) begin
            ad = a[4:0];
            a_raddr = {ad, ad};
            #1;
            total++;
            if (a_rdata !== 64'h0 || a_rpend !== 2'b00) begin
                bad++;
                $display("FAIL post_clear addr=%0d: rdata %h rpend %b want 0 0", a, a_rdata, a_rpend);
            end
        end
        @(negedge clk);
    endtask

    // Write reg3 and read on every port; writes to reg0 dropped
    task automatic test_write_read();
        a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h12345678;
        a_raddr = {5'd3, 5'd3};
        @(negedge clk);
        a_idle();
        #1;
        total++;
        if (a_rdata !== {32'h12345678, 32'h12345678}) begin
            bad++;
            $display("FAIL wr_rd_reg3: got %h want %h", a_rdata, {32'h12345678, 32'h12345678});
        end
        a_we = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        a_idle();
        a_raddr = {5'd0, 5'd0};
        #1;
        total++;
        if (a_rdata !== 64'h0 || a_rpend !== 2'b00) begin
            bad++;
            $display("FAIL wr_reg0: rdata %h rpend %b want 0 0", a_rdata, a_rpend);
        end
        @(negedge clk);
    endtask

    // Reserve, write-back clear, and same-cycle reserve+write (reserve wins)
    task automatic test_scoreboard();
        a_raddr = {5'd3, 5'd7};
        #1;
        total++;
        if (a_rpend !== 2'b00) begin
            bad++;
            $display("FAIL sb_initial: got %b want 00", a_rpend);
        end
        a_rsv_valid = 1'b1; a_rsv_addr = 5'd7;
        @(negedge clk);
        a_idle();
        #1;
        total++;
        if (a_rpend !== 2'b01) begin
            bad++;
            $display("FAIL sb_reserve: got %b want 01", a_rpend);
        end
        a_we = 1'b1; a_waddr = 5'd7; a_wdata = 32'h000000A5;
        @(negedge clk);
        a_idle();
        #1;
        total++;
        if (a_rpend !== 2'b00 || a_rdata[31:0] !== 32'h000000A5) begin
            bad++;
            $display("FAIL sb_writeback: rpend %b rdata %h want 00 000000a5", a_rpend, a_rdata[31:0]);
        end
        a_we = 1'b1; a_waddr = 5'd7; a_wdata = 32'h5A5A5A5A;
        a_rsv_valid = 1'b1; a_rsv_addr = 5'd7;
        @(negedge clk);
        a_idle();
        #1;
        total++;
        if (a_rpend !== 2'b01 || a_rdata[31:0] !== 32'h5A5A5A5A) begin
            bad++;
            $display("FAIL sb_set_wins: rpend %b rdata %h want 01 5a5a5a5a", a_rpend, a_rdata[31:0]);
        end
        a_rsv_valid = 1'b1; a_rsv_addr = 5'd0;
        @(negedge clk);
        a_idle();
        a_raddr = {5'd0, 5'd7};
        #1;
        total++;
        if (a_rpend !== 2'b01) begin
            bad++;
            $display("FAIL sb_reg0: got %b want 01", a_rpend);
        end
        @(negedge clk);
    endtask

    // Same-cycle read of the register being written on port 1
    task automatic test_bypass();
        a_rsv_valid = 1'b1; a_rsv_addr = 5'd9;
        @(negedge clk);
        a_idle();
        a_raddr = {5'd9, 5'd0};
        a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'h00000055;
        #1;
        total++;
`ifdef REGFILE_BYPASS_EN
        if (a_rdata[63:32] !== 32'h00000055 || a_rpend[1] !== 1'b0) begin
            bad++;
            $display("FAIL bypass_same_cycle: rdata %h rpend %b want 00000055 0", a_rdata[63:32], a_rpend[1]);
        end
`else
        if (a_rdata[63:32] !== 32'h00000000 || a_rpend[1] !== 1'b1) begin
            bad++;
            $display("FAIL nobypass_same_cycle: rdata %h rpend %b want 00000000 1", a_rdata[63:32], a_rpend[1]);
        end
`endif
        @(negedge clk);
        a_idle();
        #1;
        total++;
        if (a_rdata[63:32] !== 32'h00000055 || a_rpend[1] !== 1'b0) begin
            bad++;
            $display("FAIL bypass_next_cycle: rdata %h rpend %b want 00000055 0", a_rdata[63:32], a_rpend[1]);
        end
        @(negedge clk);
    endtask

    // Reset re-asserted at clear cycle 10 restarts the full sweep
    task automatic test_reset_midclear();
        logic [4:0] ad;
        a_rsv_valid = 1'b1; a_rsv_addr = 5'd12;
        @(negedge clk);
        a_idle();
        a_raddr = {5'd12, 5'd7};
        #1;
        total++;
        if (a_rpend !== 2'b11) begin
            bad++;
            $display("FAIL midclr_pre_pend: got %b want 11", a_rpend);
        end
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        total++;
        if (a_ready !== 1'b0) begin
            bad++;
            $display("FAIL midclr_cycle10_ready: got %b want 0", a_ready);
        end
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        for (int n = 0; n <= 31; n++) begin
            #1;
            total++;
            if (a_ready !== (n == 31)) begin
                bad++;
                $display("FAIL midclr_ready n=%0d: got %b want %b", n, a_ready, (n == 31));
            end
            @(negedge clk);
        end
        for (int a = 0; a < 32; a++) begin
            ad = a[4:0];
            a_raddr = {ad, ad};
            #1;
            total++;
            if (a_rdata !== 64'h0 || a_rpend !== 2'b00) begin
                bad++;
                $display("FAIL midclr_after addr=%0d: rdata %h rpend %b want 0 0", a, a_rdata, a_rpend);
            end
        end
        @(negedge clk);
    endtask

    // 64-bit, 16-entry, 3-port instance: clear, write/read, scoreboard
    task automatic test_param();
        b_idle();
        b_raddr = '0;
        b_rst = 1'b0;
        for (int n = 0; n <= 15; n++) begin
            #1;
            total++;
            if (b_ready !== (n == 15)) begin
                bad++;
                $display("FAIL p_ready n=%0d: got %b want %b", n, b_ready, (n == 15));
            end
            @(negedge clk);
        end
        b_we = 1'b1; b_waddr = 4'd3; b_wdata = 64'h0123456789ABCDEF;
        @(negedge clk);
        b_idle();
        b_raddr = {4'd3, 4'd3, 4'd3};
        #1;
        total++;
        if (b_rdata !== {3{64'h0123456789ABCDEF}}) begin
            bad++;
            $display("FAIL p_wr_rd_reg3: got %h want %h", b_rdata, {3{64'h0123456789ABCDEF}});
        end
        b_we = 1'b1; b_waddr = 4'd15; b_wdata = 64'hFEDCBA9876543210;
        @(negedge clk);
        b_idle();
        b_raddr = {4'd3, 4'd15, 4'd0};
        #1;
        total++;
        if (b_rdata !== {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0}) begin
            bad++;
            $display("FAIL p_wr_rd_reg15: got %h want %h", b_rdata, {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0});
        end
        b_we = 1'b1; b_waddr = 4'd0; b_wdata = '1;
        @(negedge clk);
        b_idle();
        b_raddr = '0;
        #1;
        total++;
        if (b_rdata !== 192'h0) begin
            bad++;
            $display("FAIL p_wr_reg0: got %h want 0", b_rdata);
        end
        b_rsv_valid = 1'b1; b_rsv_addr = 4'd7;
        @(negedge clk);
        b_idle();
        b_raddr = {4'd7, 4'd3, 4'd0};
        #1;
        total++;
        if (b_rpend !== 3'b100) begin
            bad++;
            $display("FAIL p_sb_reserve: got %b want 100", b_rpend);
        end
        b_we = 1'b1; b_waddr = 4'd7; b_wdata = 64'h00000000000000A5;
        @(negedge clk);
        b_idle();
        #1;
        total++;
        if (b_rpend !== 3'b000 || b_rdata[191:128] !== 64'h00000000000000A5) begin
            bad++;
            $display("FAIL p_sb_writeback: rpend %b rdata %h want 000 a5", b_rpend, b_rdata[191:128]);
        end
        b_we = 1'b1; b_waddr = 4'd7; b_wdata = 64'hC3C3C3C3C3C3C3C3;
        b_rsv_valid = 1'b1; b_rsv_addr = 4'd7;
        @(negedge clk);
        b_idle();
        #1;
        total++;
        if (b_rpend !== 3'b100 || b_rdata[191:128] !== 64'hC3C3C3C3C3C3C3C3) begin
            bad++;
            $display("FAIL p_sb_set_wins: rpend %b rdata %h want 100 c3c3c3c3c3c3c3c3", b_rpend, b_rdata[191:128]);
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        a_rst = 1'b1;
        b_rst = 1'b1;
        a_raddr = '0;
        b_raddr = '0;
        a_idle();
        b_idle();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_scoreboard();
        test_bypass();
        test_reset_midclear();
        test_param();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
